// File: rtl/spatz_issue_scheduler.sv
// spatz_issue_scheduler: one-entry issue buffer with a vector-register write scoreboard and per-unit outstanding limits
module spatz_issue_scheduler #(
  parameter int NrVRegs        = 32,
  parameter int MaxOutstanding = 4,
  parameter int IdWidth        = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [1:0]         req_unit_i,
  input  logic [IdWidth-1:0] req_id_i,
  input  logic [4:0]         req_vd_i,
  input  logic [4:0]         req_vs1_i,
  input  logic [4:0]         req_vs2_i,
  input  logic               req_use_vd_i,
  input  logic               req_use_vs1_i,
  input  logic               req_use_vs2_i,
  output logic [2:0]         fu_valid_o,
  input  logic [2:0]         fu_ready_i,
  output logic [IdWidth-1:0] iss_id_o,
  output logic [4:0]         iss_vd_o,
  input  logic [2:0]         done_valid_i,
  input  logic [2:0]         done_wb_i,
  input  logic [14:0]        done_vd_i,
  output logic               issued_o,
  output logic               busy_o,
  output logic [NrVRegs-1:0] sb_o
);
  localparam int CW = $clog2(MaxOutstanding + 1);
  typedef enum logic {EMPTY, HOLD} state_e;
  typedef struct packed {
    logic [1:0]         unit;
    logic [IdWidth-1:0] id;
    logic [4:0]         vd;
    logic [4:0]         vs1;
    logic [4:0]         vs2;
    logic               use_vd;
    logic               use_vs1;
    logic               use_vs2;
  } req_t;
  state_e state_q, state_d;
  req_t req_q, req_d;
  logic [NrVRegs-1:0] sb_q, sb_d;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  logic [2:0] fu_sel, cnt_full, cnt_nz;
  logic hold, hazard, cap, dispatch, accept;
  always_comb begin
    for (int u = 0; u < 3; u++) begin
      fu_sel[u]   = req_q.unit == 2'(u);
      cnt_full[u] = cnt_q[u] == CW'(MaxOutstanding);
      cnt_nz[u]   = cnt_q[u] != '0;
    end
    hold     = state_q == HOLD;
    hazard   = (req_q.use_vs1 && sb_q[req_q.vs1]) || (req_q.use_vs2 && sb_q[req_q.vs2]) ||
               (req_q.use_vd && sb_q[req_q.vd]);
    cap      = |(fu_sel & cnt_full);
    fu_valid_o = (hold && !hazard && !cap) ? fu_sel : 3'b000;
    dispatch = hold && !hazard && (req_q.unit == 2'd3 || |(fu_valid_o & fu_ready_i));
    req_ready_o = !hold || dispatch;
    accept   = req_valid_i && req_ready_o;
    state_d  = accept ? HOLD : dispatch ? EMPTY : state_q;
    req_d    = accept ? req_t'{req_unit_i, req_id_i, req_vd_i, req_vs1_i, req_vs2_i,
                               req_use_vd_i, req_use_vs1_i, req_use_vs2_i} : req_q;
    for (int u = 0; u < 3; u++)
      cnt_d[u] = cnt_q[u] + CW'(dispatch && fu_sel[u]) - CW'(done_valid_i[u] && cnt_nz[u]);
    sb_d = sb_q;
    for (int u = 0; u < 3; u++)
      if (done_valid_i[u] && done_wb_i[u]) sb_d[done_vd_i[5*u +: 5]] = 1'b0;
    // Applied after the clears so a new writer's set beats an older writer's done
    if (dispatch && req_q.use_vd && req_q.unit != 2'd3) sb_d[req_q.vd] = 1'b1;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      req_q   <= '0;
      sb_q    <= '0;
      for (int u = 0; u < 3; u++) cnt_q[u] <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      sb_q    <= sb_d;
      for (int u = 0; u < 3; u++) cnt_q[u] <= cnt_d[u];
    end
  end
  assign iss_id_o = hold ? req_q.id : '0;
  assign iss_vd_o = hold ? req_q.vd : '0;
  assign issued_o = dispatch;
  assign busy_o   = hold || |cnt_nz;
  assign sb_o     = sb_q;
  // A done on an idle unit means the unit and the scheduler disagree on what is in flight
  done_on_idle_unit: assert property (@(posedge clk_i) disable iff (rst_i)
    (done_valid_i & ~cnt_nz) == 3'b000);
endmodule
